sha512_msg_padder: RTL



---
 rtl/sha512_pkg.sv | 24 ++
 rtl/sha512_word_mask.sv | 25 ++
 rtl/sha512_msg_padder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sha512_pkg.sv
// Shared definitions for the SHA-512 message padder.
//   SHA512_IV      : initial chaining value H0..H7, H0 in [511:448]
//   padder_state_e : padder control states
//   PAD_WORD       : word carrying the 0x80 end-of-message marker
package sha512_pkg;

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    ISSUE,
    WAIT
  } padder_state_e;

endpackage

// File: rtl/sha512_word_mask.sv
// Combinational tail-word formatter.
//   i_data  : big-endian message word, first byte in [63:56]
//   i_bytes : number of valid bytes, counted from the MSB
//   i_last  : word is the final word of the message
//   o_word  : i_data with bytes at index >= i_bytes cleared; when i_last is
//             set and i_bytes < 8, byte i_bytes carries the 0x80 marker
module sha512_word_mask (
  input  logic [63:0] i_data,
  input  logic [3:0]  i_bytes,
  input  logic        i_last,
  output logic [63:0] o_word
);

  always_comb begin
    o_word = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < 32'(i_bytes)) begin
        o_word[63 - 8*k -: 8] = i_data[63 - 8*k -: 8];
      end else if ((k == 32'(i_bytes)) && i_last) begin
        o_word[63 - 8*k -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: packs a big-endian 64-bit word stream into
// 1024-bit blocks, appends the 0x80 marker, zero fill and 128-bit bit
// length, issues each block to an external compression core and keeps
// the chaining value between blocks.
//   clk, rst            : clock; synchronous active-low reset
//   in_data/in_bytes    : message word and its valid byte count (from MSB)
//   in_last/in_valid    : final-word marker / word offered
//   in_ready            : word accepted when in_valid && in_ready
//   cmp_start           : one-cycle start pulse to the core
//   cmp_block, cmp_h_in : block (word0 in [1023:960]) and chaining value
//   cmp_end, cmp_h_out  : core done pulse with updated chaining value
//   digest/digest_valid : final hash and its one-cycle update pulse
module sha512_msg_padder
  import sha512_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   in_data,
  input  logic [3:0]    in_bytes,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          cmp_start,
  output logic [1023:0] cmp_block,
  output logic [511:0]  cmp_h_in,
  input  logic          cmp_end,
  input  logic [511:0]  cmp_h_out,
  output logic [511:0]  digest,
  output logic          digest_valid
);

  padder_state_e r_state;
  padder_state_e w_state_nxt;

  logic [4:0]       r_wcnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_pad_pending;
  logic             r_msg_done;
  logic             r_len_done;
  // Set when the 0x80 marker lands in word 14 or 15: the length no longer
  // fits, so the rest of this block stays zero and a length block follows.
  logic             r_defer;
  logic [511:0]     r_h;
  logic [511:0]     r_digest;
  logic             r_digest_valid;
  logic [63:0]      r_buf [16];

  logic             w_accept;
  logic [63:0]      w_word;
  logic [3:0]       w_idx;
  logic [CNT_W-1:0] w_cnt_base;
  logic [127:0]     w_bitlen;

  sha512_word_mask u_mask (
    .i_data  (in_data),
    .i_bytes (in_bytes),
    .i_last  (in_last),
    .o_word  (w_word)
  );

  assign w_accept = in_valid && in_ready;

  // A word accepted in IDLE starts a new message at word 0 / count 0.
  assign w_idx      = (r_state == IDLE) ? 4'd0 : r_wcnt[3:0];
  assign w_cnt_base = (r_state == IDLE) ? '0   : r_byte_cnt;
  assign w_bitlen   = 128'(r_byte_cnt) << 3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_last ? PAD : FILL;
        end
      end
      FILL: begin
        if (w_accept) begin
          if (r_wcnt == 5'd15) begin
            w_state_nxt = ISSUE;
          end else if (in_last) begin
            w_state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (r_wcnt == 5'd15) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (cmp_end) begin
          if (r_len_done) begin
            w_state_nxt = IDLE;
          end else if (r_msg_done) begin
            w_state_nxt = PAD;
          end else begin
            w_state_nxt = FILL;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    cmp_start = 1'b0;
    if (rst) begin
      in_ready  = (r_state == IDLE) || (r_state == FILL);
      cmp_start = (r_state == ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wcnt         <= '0;
      r_byte_cnt     <= '0;
      r_pad_pending  <= 1'b0;
      r_msg_done     <= 1'b0;
      r_len_done     <= 1'b0;
      r_defer        <= 1'b0;
      r_h            <= SHA512_IV;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_digest_valid <= 1'b0;
      case (r_state)
        IDLE, FILL: begin
          if (w_accept) begin
            if (r_state == IDLE) begin
              r_h           <= SHA512_IV;
              r_pad_pending <= 1'b0;
              r_msg_done    <= 1'b0;
              r_len_done    <= 1'b0;
              r_defer       <= 1'b0;
            end
            r_buf[w_idx] <= w_word;
            r_byte_cnt   <= w_cnt_base + CNT_W'(in_bytes);
            r_wcnt       <= {1'b0, w_idx} + 5'd1;
            if (in_last) begin
              r_msg_done <= 1'b1;
              if (in_bytes >= 4'd8) begin
                r_pad_pending <= 1'b1;
              end else if (w_idx >= 4'd14) begin
                r_defer <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          if (r_pad_pending) begin
            r_buf[r_wcnt[3:0]] <= PAD_WORD;
            r_pad_pending      <= 1'b0;
            if (r_wcnt >= 5'd14) begin
              r_defer <= 1'b1;
            end
          end else if ((r_wcnt == 5'd14) && !r_defer) begin
            r_buf[r_wcnt[3:0]] <= w_bitlen[127:64];
          end else if ((r_wcnt == 5'd15) && !r_defer) begin
            r_buf[r_wcnt[3:0]] <= w_bitlen[63:0];
            r_len_done         <= 1'b1;
          end else begin
            r_buf[r_wcnt[3:0]] <= '0;
          end
          r_wcnt <= r_wcnt + 5'd1;
        end
        WAIT: begin
          if (cmp_end) begin
            r_h     <= cmp_h_out;
            r_wcnt  <= '0;
            r_defer <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
              r_buf[i] <= '0;
            end
            if (r_len_done) begin
              r_digest       <= cmp_h_out;
              r_digest_valid <= 1'b1;
              r_len_done     <= 1'b0;
              r_msg_done     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmp_block = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cmp_block[1023 - 64*i -: 64] = r_buf[i];
    end
  end

  assign cmp_h_in     = r_h;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;

endmodule
